// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   txbuf_state_t   : transmit-buffer launch FSM states
//   TXBUF_DEPTH_DEF : default FIFO depth of uart_tx_buffer
//   UART_BYTE_W     : width of one UART data byte
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int TXBUF_DEPTH_DEF = 8;
    localparam int UART_BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GUARD  = 2'd2,
        WAIT   = 2'd3
    } txbuf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with registered full/empty/count flags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : push request / data (ignored while full)
//   rd_en           : pop request (ignored while empty)
//   rd_data         : entry at the read pointer (combinational read)
//   full, empty     : occupancy flags
//   count           : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push;
    logic          pop;

    // A push while full is rejected even if a pop happens in the same cycle.
    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // DEPTH is a power of two, so pointer increments wrap naturally.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Byte FIFO in front of the UART transmitter. Producers push at clock rate;
// bytes are launched to the UART one at a time with a trmt pulse and the
// next launch waits for tx_done. Wire order equals push order.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : producer push
//   full, empty     : FIFO occupancy flags
//   count           : FIFO occupancy
//   ovf, ovf_clr    : sticky dropped-push flag and its clear
//   trmt, tx_data   : one-cycle start pulse and byte to the UART
//   tx_done         : UART frame-complete level
//   busy            : a frame is in flight
//   ovf_cnt         : saturating dropped-push counter
// Build option: define UART_TXBUF_OVF_CNT_EN to add ovf_cnt.
//
// state  | meaning
// IDLE   | no frame in flight; load tx_data when the FIFO has a byte
// LAUNCH | trmt high for this cycle; FIFO entry popped
// GUARD  | tx_done may still be high from the previous frame; ignore it
// WAIT   | wait for tx_done from the UART
// ---------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = TXBUF_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   trmt,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_done,
    output logic                   busy
`ifdef UART_TXBUF_OVF_CNT_EN
    ,
    output logic [15:0]            ovf_cnt
`endif
);

    txbuf_state_t           state_q, state_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   trmt_q, trmt_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   pop;
    logic                   drop;
    logic [UART_BYTE_W-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    tx_data_d = fifo_rd_data;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                pop     = 1'b1;
                state_d = GUARD;
            end
            GUARD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Decoded from the next state so trmt/busy are true flops aligned
        // with the state they describe.
        trmt_d = (state_d == LAUNCH);
        busy_d = (state_d != IDLE);
    end

    assign drop = wr_en && full;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)   ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef UART_TXBUF_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr)                          ovf_cnt_d = '0;
        else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign tx_data = tx_data_q;
    assign trmt    = trmt_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte buffer sitting directly upstream of the UART transmitter. Producer logic (bus interface, test pattern generator) pushes bytes at full clock rate; the buffer stores them in a small FIFO and feeds the UART one byte at a time via its `trmt` / `tx_data` / `tx_done` handshake, so producers never stall on the serial rate. Byte order on the wire equals push order.

## Interface
Parameters:
- `DEPTH`, default 8 — FIFO entries; a power of 2, at least 2.

Ports:
- `clk`  in  1 — system clock; all logic is rising-edge.
- `rst`  in  1 — synchronous, active-high reset.
- `wr_en`  in  1 — push request from the producer.
- `wr_data`  in  8 — byte to push.
- `full`  out  1 — FIFO holds `DEPTH` bytes.
- `empty`  out  1 — FIFO holds 0 bytes.
- `count`  out  `$clog2(DEPTH)+1` — current occupancy.
- `ovf`  out  1 — sticky flag: a push was dropped.
- `ovf_clr`  in  1 — clears `ovf` (and `ovf_cnt` when present).
- `trmt`  out  1 — one-cycle start pulse to the UART transmitter.
- `tx_data`  out  8 — byte presented to the UART.
- `tx_done`  in  1 — UART level flag: high when the frame is complete; the UART clears it within 1 cycle after `trmt`.
- `busy`  out  1 — a frame is in flight (state is not IDLE).
- `ovf_cnt`  out  16 — dropped-push counter; present only with `UART_TXBUF_OVF_CNT_EN`.

## Operation
- **Push.** A push is accepted when `wr_en && !full`. `wr_data` is written at the write pointer, and the pointer wraps modulo `DEPTH`.
- **Dropped push.** `wr_en && full` drops the byte and sets `ovf`.
  - A push while `full` is dropped even if a pop occurs in the same cycle.
- **Overflow clear.** `ovf_clr` has priority over a same-cycle set.
- **Pop.** The read pointer advances, wrapping, at the end of the LAUNCH cycle.
- **Occupancy.** `count` reflects a simultaneous push and pop with a net change of 0.
- **State machine** (type `txbuf_state_t`):
  - **IDLE:** if `!empty`, register `tx_data <= mem[rd_ptr]` and go to LAUNCH.
  - **LAUNCH:** `trmt = 1` for exactly this cycle; pop; go to GUARD.
  - **GUARD:** ignore `tx_done` (it may still be high from the previous frame); go to WAIT.
  - **WAIT:** stay until `tx_done == 1`, then go to IDLE.
- **`tx_data`** holds its value from entry to LAUNCH until the next launch.
- **`busy`** is 1 in LAUNCH, GUARD and WAIT.

**Reset** (any cycle, including mid-frame): state IDLE; pointers and `count` 0; `empty` 1; `full` 0; `trmt` 0; `tx_data` 0x00; `busy` 0; `ovf` 0; `ovf_cnt` 0. Buffered bytes are discarded. The UART has its own reset, so a frame already started completes on the wire; the buffer does not wait for it.

## Timing
- `full`, `empty`, `count`, `ovf`, `trmt`, `tx_data` and `busy` are registered outputs.
- **Push latency:** a push in cycle N into an empty, idle buffer gives `count = 1` / `empty = 0` in N+1 and `trmt = 1` in N+2.
- **Occupancy after pop:** `count` decrements in the cycle after LAUNCH.
- **Gap between frames:** at least 1 IDLE cycle between the WAIT exit and the next LAUNCH. Back-to-back frames are separated by UART frame time plus 2 cycles.
- **`tx_done` sampling:** `tx_done` is sampled only in WAIT.

## Configuration
- `UART_TXBUF_OVF_CNT_EN` defined:
  - adds the `ovf_cnt` port;
  - `ovf_cnt` increments on each dropped push and saturates at 0xFFFF;
  - `ovf_clr` zeroes it, with priority over a same-cycle increment.
- Not defined: no `ovf_cnt` port and no counter logic; only the sticky `ovf` flag exists.

## Structure
- Shared package `uart_pkg`:
  - `txbuf_state_t` enum (IDLE, LAUNCH, GUARD, WAIT);
  - `TXBUF_DEPTH_DEF = 8`;
  - `UART_BYTE_W = 8`.
- Sub-module `uart_sync_fifo`:
  - parameterized by depth and width;
  - generates full/empty/count and the pointers.
- The top level holds the FSM, the `tx_data` register and the overflow logic.

## Test plan
1. **Reset values.** Assert `rst` 3 cycles → all outputs at reset values (`empty` = 1, all others 0).
2. **Single byte.** Push 0xA5 in cycle N → `trmt` = 1 only in N+2; `tx_data` = 0xA5 held; `busy` high until a UART model raises `tx_done`, then IDLE.
3. **Fill and overflow.** Behavioral UART (`tx_done` after 100 cycles). Push 0x00..0x08 (9 bytes) in consecutive cycles → 0x00 launches and the FIFO reaches `full`. Check that:
   - any push made while `full` is dropped and `ovf` = 1;
   - the wire order matches the accepted bytes;
   - `ovf_clr` clears `ovf`.
4. **Stale `tx_done`.** Hold `tx_done` high from the previous frame and clear it 1 cycle after `trmt` → no early WAIT exit; the next byte launches only after the new `tx_done`.
5. **Reset mid-frame.** Assert `rst` in WAIT with 3 bytes queued → IDLE, `count` = 0, no further `trmt`.
6. **Counter saturation.** With `UART_TXBUF_OVF_CNT_EN`: preload near saturation (force), push while `full` → `ovf_cnt` saturates at 0xFFFF; `ovf_clr` plus a same-cycle drop gives 0.
